// File: rtl/axi4lite_master_bridge.sv
// axi4lite_master_bridge: converts a simple request/ack bus into AXI4-Lite master transactions.
// At most one transaction is outstanding. AW and W are issued together and may complete in any
// order. Optional response watchdog is enabled by defining AXI4LITE_BRIDGE_TIMEOUT_EN; without it
// the bridge waits indefinitely for B/R responses and TIMEOUT_CYCLES has no effect.
module axi4lite_master_bridge #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   // request side
   input  logic                    req,
   input  logic                    req_is_wr,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH-1:0]   wr_biten,
   output logic                    req_stall,
   output logic                    rd_ack,
   output logic                    rd_err,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    wr_ack,
   output logic                    wr_err,
   // AXI4-Lite master side
   output logic                    m_axil_awvalid,
   input  logic                    m_axil_awready,
   output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
   output logic [2:0]              m_axil_awprot,
   output logic                    m_axil_wvalid,
   input  logic                    m_axil_wready,
   output logic [DATA_WIDTH-1:0]   m_axil_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
   input  logic                    m_axil_bvalid,
   output logic                    m_axil_bready,
   input  logic [1:0]              m_axil_bresp,
   output logic                    m_axil_arvalid,
   input  logic                    m_axil_arready,
   output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
   output logic [2:0]              m_axil_arprot,
   input  logic                    m_axil_rvalid,
   output logic                    m_axil_rready,
   input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
   input  logic [1:0]              m_axil_rresp
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;

   // Reject unusable configurations at elaboration time.
   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("axi4lite_master_bridge: DATA_WIDTH must be a nonzero multiple of 8, TIMEOUT_CYCLES > 0");
   end

   typedef enum logic [2:0] {
      StIdle,
      StWrAwW,
      StWrResp,
      StRdAr,
      StRdData,
      StDrain
   } state_e;

   state_e                 state_q, state_d;
   logic                   awvalid_q, awvalid_d;
   logic                   wvalid_q, wvalid_d;
   logic                   arvalid_q, arvalid_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
   logic                   wr_ack_q, wr_ack_d;
   logic                   wr_err_q, wr_err_d;
   logic                   rd_ack_q, rd_ack_d;
   logic                   rd_err_q, rd_err_d;
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [StrbWidth-1:0]   strb_in;
   logic                   aw_hs, w_hs, ar_hs;

`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
   localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CntWidth-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                tmo_hit;
   assign tmo_hit = (tmo_cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));
`endif

   // Only the error bit of each response is meaningful to the request side.
   logic unused_resp;
   assign unused_resp = ^{m_axil_bresp[0], m_axil_rresp[0]};

   // Byte strobe is set when any bit of that byte is enabled.
   always_comb begin
      strb_in = '0;
      for (int i = 0; i < StrbWidth; i++) begin
         strb_in[i] = |wr_biten[8*i +: 8];
      end
   end

   assign aw_hs = awvalid_q & m_axil_awready;
   assign w_hs  = wvalid_q & m_axil_wready;
   assign ar_hs = arvalid_q & m_axil_arready;

   // Next-state, channel-valid and ack/response decode.
   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wr_ack_d  = 1'b0;
      wr_err_d  = 1'b0;
      rd_ack_d  = 1'b0;
      rd_err_d  = 1'b0;
      rd_data_d = '0;
`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req) begin
               addr_d  = addr;
               wdata_d = wr_data;
               wstrb_d = strb_in;
               if (req_is_wr) begin
                  state_d   = StWrAwW;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = StRdAr;
                  arvalid_d = 1'b1;
               end
            end
         end
         StWrAwW: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            // A channel is finished if it handshakes now or already dropped its valid.
            if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
               state_d = StWrResp;
`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         StWrResp: begin
            if (m_axil_bvalid) begin
               wr_ack_d = 1'b1;
               wr_err_d = m_axil_bresp[1];
               state_d  = StIdle;
            end
`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
            else if (tmo_hit) begin
               wr_ack_d = 1'b1;
               wr_err_d = 1'b1;
               state_d  = StDrain;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CntWidth'(1);
            end
`endif
         end
         StRdAr: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               state_d   = StRdData;
`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         StRdData: begin
            if (m_axil_rvalid) begin
               rd_ack_d  = 1'b1;
               rd_err_d  = m_axil_rresp[1];
               rd_data_d = m_axil_rdata;
               state_d   = StIdle;
            end
`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
            else if (tmo_hit) begin
               rd_ack_d = 1'b1;
               rd_err_d = 1'b1;
               state_d  = StDrain;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CntWidth'(1);
            end
`endif
         end
         StDrain: begin
            // Swallow the late response of the abandoned transaction without acking it.
            if (m_axil_bvalid || m_axil_rvalid) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wr_ack_q  <= 1'b0;
         wr_err_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         rd_err_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wr_ack_q  <= wr_ack_d;
         wr_err_q  <= wr_err_d;
         rd_ack_q  <= rd_ack_d;
         rd_err_q  <= rd_err_d;
         rd_data_q <= rd_data_d;
      end
   end

`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
   // Response watchdog counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

   assign req_stall      = (state_q != StIdle);
   assign rd_ack         = rd_ack_q;
   assign rd_err         = rd_err_q;
   assign rd_data        = rd_data_q;
   assign wr_ack         = wr_ack_q;
   assign wr_err         = wr_err_q;

   assign m_axil_awvalid = awvalid_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_bready  = (state_q == StWrResp) || (state_q == StDrain);
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_rready  = (state_q == StRdData) || (state_q == StDrain);

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// tb_axi4lite_master_bridge: randomized bench for axi4lite_master_bridge (default build).
// The bench plays the AXI slave with per-channel delays and predicts channel contents, strobes,
// response flags and accept-to-ack latency from the transaction parameters.
module tb_axi4lite_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, req_is_wr;
   logic [31:0] addr, wr_data, wr_biten;
   logic        req_stall, rd_ack, rd_err, wr_ack, wr_err;
   logic [31:0] rd_data;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [2:0]  awprot, arprot;
   logic [1:0]  bresp, rresp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi4lite_master_bridge dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_is_wr     (req_is_wr),
      .addr          (addr),
      .wr_data       (wr_data),
      .wr_biten      (wr_biten),
      .req_stall     (req_stall),
      .rd_ack        (rd_ack),
      .rd_err        (rd_err),
      .rd_data       (rd_data),
      .wr_ack        (wr_ack),
      .wr_err        (wr_err),
      .m_axil_awvalid(awvalid),
      .m_axil_awready(awready),
      .m_axil_awaddr (awaddr),
      .m_axil_awprot (awprot),
      .m_axil_wvalid (wvalid),
      .m_axil_wready (wready),
      .m_axil_wdata  (wdata),
      .m_axil_wstrb  (wstrb),
      .m_axil_bvalid (bvalid),
      .m_axil_bready (bready),
      .m_axil_bresp  (bresp),
      .m_axil_arvalid(arvalid),
      .m_axil_arready(arready),
      .m_axil_araddr (araddr),
      .m_axil_arprot (arprot),
      .m_axil_rvalid (rvalid),
      .m_axil_rready (rready),
      .m_axil_rdata  (rdata),
      .m_axil_rresp  (rresp)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A byte strobe is on when any enable bit in that byte is on.
   function automatic logic [3:0] exp_strb(input logic [31:0] be);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 4; i++) s[i] = (((be >> (8 * i)) & 32'hFF) != 0);
      return s;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_stall"}, req_stall, 0);
      check_eq({tag, "_valids"}, {awvalid, wvalid, arvalid}, 0);
      check_eq({tag, "_readys"}, {bready, rready}, 0);
      check_eq({tag, "_acks"}, {wr_ack, wr_err, rd_ack, rd_err}, 0);
      check_eq({tag, "_rdata"}, rd_data, 0);
   endtask

   // Full write; called at a negedge with the bridge idle, returns one cycle after the ack.
   task automatic run_wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] be,
                         input int aw_d, input int w_d, input int b_d, input logic [1:0] resp);
      bit aw_done, w_done;
      int lat, k, exp_lat;
      exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
      check_eq("wr_pre_stall", req_stall, 0);
      req = 1'b1; req_is_wr = 1'b1; addr = a; wr_data = d; wr_biten = be;
      @(negedge clk);
      req = 1'b0; addr = $urandom; wr_data = $urandom; wr_biten = $urandom;
      lat = 1; k = 0; aw_done = 0; w_done = 0;
      while (!(aw_done && w_done) && k < 64) begin
         check_eq("wr_stall", req_stall, 1);
         check_eq("wr_bready_early", bready, 0);
         if (!aw_done) begin
            check_eq("awvalid", awvalid, 1);
            check_eq("awaddr", awaddr, a);
            check_eq("awprot", awprot, 0);
            awready = (k >= aw_d);
         end else begin
            check_eq("awvalid_drop", awvalid, 0);
         end
         if (!w_done) begin
            check_eq("wvalid", wvalid, 1);
            check_eq("wdata", wdata, d);
            check_eq("wstrb", wstrb, exp_strb(be));
            wready = (k >= w_d);
         end else begin
            check_eq("wvalid_drop", wvalid, 0);
         end
         @(posedge clk);
         if (awready) aw_done = 1;
         if (wready)  w_done  = 1;
         @(negedge clk);
         awready = 1'b0; wready = 1'b0;
         lat++; k++;
      end
      check_eq("wr_aw_w_bound", aw_done && w_done, 1);
      for (int j = 0; j < b_d; j++) begin
         check_eq("wr_bready_wait", bready, 1);
         check_eq("wr_ack_early", wr_ack, 0);
         @(negedge clk);
         lat++;
      end
      bvalid = 1'b1; bresp = resp;
      check_eq("bready", bready, 1);
      check_eq("wr_valids_done", {awvalid, wvalid}, 0);
      @(negedge clk);
      lat++;
      bvalid = 1'b0; bresp = 2'($urandom);
      check_eq("wr_ack", wr_ack, 1);
      check_eq("wr_err", wr_err, resp[1]);
      check_eq("wr_no_rd_ack", {rd_ack, rd_err}, 0);
      check_eq("wr_rd_data_zero", rd_data, 0);
      check_eq("wr_latency", lat, exp_lat);
      check_eq("wr_ack_stall", req_stall, 0);
      check_eq("wr_ack_bready", bready, 0);
      @(negedge clk);
      check_eq("wr_ack_pulse", {wr_ack, wr_err}, 0);
   endtask

   // Full read; same calling convention as run_wr.
   task automatic run_rd(input logic [31:0] a, input int ar_d, input int r_d,
                         input logic [31:0] d, input logic [1:0] resp);
      bit ar_done;
      int lat, k, exp_lat;
      exp_lat = 3 + ar_d + r_d;
      check_eq("rd_pre_stall", req_stall, 0);
      req = 1'b1; req_is_wr = 1'b0; addr = a; wr_data = $urandom; wr_biten = $urandom;
      @(negedge clk);
      req = 1'b0; addr = $urandom;
      lat = 1; k = 0; ar_done = 0;
      while (!ar_done && k < 64) begin
         check_eq("rd_stall", req_stall, 1);
         check_eq("arvalid", arvalid, 1);
         check_eq("araddr", araddr, a);
         check_eq("arprot", arprot, 0);
         check_eq("rready_early", rready, 0);
         check_eq("rd_no_wr_valid", {awvalid, wvalid}, 0);
         arready = (k >= ar_d);
         @(posedge clk);
         if (arready) ar_done = 1;
         @(negedge clk);
         arready = 1'b0;
         lat++; k++;
      end
      check_eq("rd_ar_bound", ar_done, 1);
      check_eq("arvalid_drop", arvalid, 0);
      for (int j = 0; j < r_d; j++) begin
         check_eq("rd_rready_wait", rready, 1);
         check_eq("rd_ack_early", rd_ack, 0);
         check_eq("rd_data_idle", rd_data, 0);
         @(negedge clk);
         lat++;
      end
      rvalid = 1'b1; rdata = d; rresp = resp;
      check_eq("rready", rready, 1);
      @(negedge clk);
      lat++;
      rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
      check_eq("rd_ack", rd_ack, 1);
      check_eq("rd_data", rd_data, d);
      check_eq("rd_err", rd_err, resp[1]);
      check_eq("rd_no_wr_ack", {wr_ack, wr_err}, 0);
      check_eq("rd_latency", lat, exp_lat);
      check_eq("rd_ack_stall", req_stall, 0);
      @(negedge clk);
      check_eq("rd_ack_pulse", {rd_ack, rd_err}, 0);
      check_eq("rd_data_after", rd_data, 0);
   endtask

   function automatic logic [31:0] rand_biten();
      logic [31:0] be;
      be = '0;
      for (int i = 0; i < 4; i++) begin
         case ($urandom_range(0, 2))
            0:       be[8*i +: 8] = 8'h00;
            1:       be[8*i +: 8] = 8'hFF;
            default: be[8*i +: 8] = 8'(1 << $urandom_range(0, 7));
         endcase
      end
      return be;
   endfunction

   // Hard stop in case the DUT wedges somewhere the bounded loops do not cover.
   initial begin
      #500000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst = 1'b1;
      req = 1'b0; req_is_wr = 1'b0; addr = '0; wr_data = '0; wr_biten = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");

      // Directed: fully ready write, byte-sparse write with late W, erroring read.
      run_wr(32'h0000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0, 0, 2'b00);
      run_wr(32'h0000_0014, 32'h1122_3344, 32'h0000_FF00, 0, 4, 1, 2'b00);
      run_rd(32'h0000_0020, 0, 0, 32'h1234_5678, 2'b10);
      run_wr(32'h0000_0003, 32'hCAFE_F00D, 32'h0100_0080, 3, 0, 2, 2'b10);

      // Back-to-back write then read with req held high.
      req = 1'b1; req_is_wr = 1'b1; addr = 32'h40; wr_data = 32'hA5A5_5A5A; wr_biten = '1;
      awready = 1'b1; wready = 1'b1;
      @(negedge clk);
      check_eq("b2b_stall_c1", req_stall, 1);
      @(negedge clk);
      check_eq("b2b_stall_c2", req_stall, 1);
      bvalid = 1'b1; bresp = 2'b00;
      @(negedge clk);
      bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
      check_eq("b2b_wr_ack", wr_ack, 1);
      check_eq("b2b_ack_stall", req_stall, 0);
      req_is_wr = 1'b0; addr = 32'h0000_0045;
      @(negedge clk);
      req = 1'b0;
      check_eq("b2b_rd_accepted", req_stall, 1);
      check_eq("b2b_arvalid", arvalid, 1);
      check_eq("b2b_araddr", araddr, 32'h0000_0045);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h0BAD_CAFE; rresp = 2'b00;
      @(negedge clk);
      rvalid = 1'b0;
      check_eq("b2b_rd_ack", rd_ack, 1);
      check_eq("b2b_rd_data", rd_data, 32'h0BAD_CAFE);
      @(negedge clk);

      // Reset while waiting for B: transaction is dropped with no ack.
      req = 1'b1; req_is_wr = 1'b1; addr = 32'h80; wr_data = 32'h1; wr_biten = '1;
      @(negedge clk);
      req = 1'b0; awready = 1'b1; wready = 1'b1;
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
      check_eq("rst_in_wr_resp", bready, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("rst_mid");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("rst_no_ack", {wr_ack, rd_ack, bready}, 0);
      end

      // Randomized mix of reads and writes with random delays and responses.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            run_wr($urandom, $urandom, rand_biten(), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2'($urandom));
         end else begin
            run_rd($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom));
         end
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
